// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and sizing for the PE array sequencer.
// Four PE rows, each with a CONFIG_W-bit configuration slice.
package pe_array_ctrl_pkg;

  localparam int CONFIG_W = 20;
  localparam int ARRAY    = 4 * CONFIG_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_INIT  = 3'd3,
    S_RUN   = 3'd4,
    S_DRAIN = 3'd5
  } ctrl_state_e;

  function automatic int ceil_div(int a, int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/pe_array_ctrl_cfg_word_assembler.sv
// Gathers config words into a shadow register and commits the
// whole array configuration in one cycle on the last word.
module cfg_word_assembler
  import pe_array_ctrl_pkg::*;
#(
  parameter int ARRAY_W    = ARRAY,
  parameter int CFG_WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  capture,
  input  logic [CFG_WORD_W-1:0] data,
  output logic                  commit,
  output logic [ARRAY_W-1:0]    pe_config
);

  localparam int N_WORDS  = ceil_div(ARRAY_W, CFG_WORD_W);
  localparam int SHADOW_W = N_WORDS * CFG_WORD_W;
  localparam int RCV_W    = $clog2(N_WORDS + 1);

  logic [SHADOW_W-1:0] shadow;
  logic [SHADOW_W-1:0] merged;
  logic [RCV_W-1:0]    rcv_cnt;

  always_comb begin
    merged = shadow;
    if (int'(rcv_cnt) < N_WORDS)
      merged[int'(rcv_cnt)*CFG_WORD_W +: CFG_WORD_W] = data;
  end

  assign commit = capture &&
                  (int'(rcv_cnt) == N_WORDS - 1);

  // Bits of the last word above ARRAY_W never reach pe_config.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow    <= '0;
      rcv_cnt   <= '0;
      pe_config <= '0;
    end else if (clear) begin
      rcv_cnt <= '0;
    end else if (capture) begin
      shadow  <= merged;
      rcv_cnt <= rcv_cnt + RCV_W'(1);
      if (commit)
        pe_config <= merged[ARRAY_W-1:0];
    end
  end

endmodule

// File: rtl/pe_array_ctrl.sv
// PE array sequencer: fetches the array config, commits it,
// then pulses init and holds run for the programmed length.
module pe_array_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter  int ARRAY_W    = ARRAY,
  parameter  int CFG_WORD_W = 32,
  parameter  int CFG_ADDR_W = 10,
  parameter  int CNT_W      = 32,
  localparam int N_WORDS    = ceil_div(ARRAY_W, CFG_WORD_W),
  localparam int OUT_W      = $clog2(N_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CFG_ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]      run_cycles,
  output logic                  cfg_rd_en,
  output logic [CFG_ADDR_W-1:0] cfg_rd_addr,
  input  logic                  cfg_rd_valid,
  input  logic [CFG_WORD_W-1:0] cfg_rd_data,
  output logic [ARRAY_W-1:0]    pe_config,
  output logic                  init,
  output logic                  run,
  output logic                  busy,
  output logic                  done
);

  ctrl_state_e           state;
  logic [CFG_ADDR_W-1:0] base;
  logic [OUT_W-1:0]      issue_cnt;
  logic [OUT_W-1:0]      out_cnt;
  logic [OUT_W-1:0]      out_next;
  logic [CNT_W-1:0]      run_cnt;
  logic                  fetching;
  logic                  accept;
  logic                  capture;
  logic                  commit;
  logic                  launch;

  assign fetching = (state == S_FETCH) ||
                    (state == S_WAIT);
  assign accept   = cfg_rd_valid && (out_cnt != '0);
  assign capture  = accept && fetching && !abort;
  assign launch   = (state == S_IDLE) && start && !abort;
  assign busy     = (state != S_IDLE);

  // Reads leaving this cycle minus valids landing this cycle.
  assign out_next = out_cnt + OUT_W'(cfg_rd_en)
                  - OUT_W'(accept);

  cfg_word_assembler #(
    .ARRAY_W    (ARRAY_W),
    .CFG_WORD_W (CFG_WORD_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (launch),
    .capture   (capture),
    .data      (cfg_rd_data),
    .commit    (commit),
    .pe_config (pe_config)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      base        <= '0;
      issue_cnt   <= '0;
      out_cnt     <= '0;
      run_cnt     <= '0;
      cfg_rd_en   <= 1'b0;
      cfg_rd_addr <= '0;
      init        <= 1'b0;
      run         <= 1'b0;
      done        <= 1'b0;
    end else begin
      out_cnt <= out_next;
      init    <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        cfg_rd_en <= 1'b0;
        run       <= 1'b0;
        if ((fetching || state == S_DRAIN) &&
            out_next != '0)
          state <= S_DRAIN;
        else
          state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state       <= S_FETCH;
              base        <= cfg_base;
              run_cnt     <= run_cycles;
              cfg_rd_en   <= 1'b1;
              cfg_rd_addr <= cfg_base;
              issue_cnt   <= OUT_W'(1);
            end
          end
          S_FETCH, S_WAIT: begin
            if (int'(issue_cnt) == N_WORDS) begin
              cfg_rd_en <= 1'b0;
              state     <= S_WAIT;
            end else begin
              cfg_rd_en   <= 1'b1;
              cfg_rd_addr <= base +
                             CFG_ADDR_W'(issue_cnt);
              issue_cnt   <= issue_cnt + OUT_W'(1);
            end
            if (commit) begin
              state <= S_INIT;
              init  <= 1'b1;
            end
          end
          S_INIT: begin
            if (run_cnt == '0) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              run   <= 1'b1;
            end
          end
          S_RUN: begin
            if (run_cnt <= CNT_W'(1)) begin
              state <= S_IDLE;
              run   <= 1'b0;
              done  <= 1'b1;
            end
            if (run_cnt != '0)
              run_cnt <= run_cnt - CNT_W'(1);
          end
          S_DRAIN: begin
            cfg_rd_en <= 1'b0;
            if (out_next == '0)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
